// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared bus widths, entry type, NOP constant and byte-swap helper for the IF->ID queue
`ifndef IF_ID_DEFINES
`define IF_ID_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`endif

package if_id_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam logic [31:0] RV_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [`InstAddrBus] pc;
        logic [`InstBus]     inst;
    } if_entry_t;

    // Big-endian memory word to RISC-V little-endian instruction.
    function automatic logic [`InstBus] byte_swap(input logic [`InstBus] inst);
        return {inst[7:0], inst[15:8], inst[23:16], inst[31:24]};
    endfunction

endpackage

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - generic DEPTH x W FIFO storage with pointers, count and push/pop/clear
module if_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID pipeline queue with byte swap, empty masking and misalign flag
// Optional perf counters (stall_cnt/bubble_cnt) under IF_ID_PERF_CNT_EN.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned INST_W    = INST_W_DEF,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned BYTE_SWAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic              id_misalign
);

    localparam int unsigned W      = ADDR_W + INST_W;
    localparam int unsigned NBYTES = INST_W / 8;

    logic [INST_W-1:0] swapped;
    logic [W-1:0]      head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    generate
        if (BYTE_SWAP != 0 && INST_W == 32) begin : g_swap32
            assign swapped = byte_swap(if_inst);
        end else if (BYTE_SWAP != 0) begin : g_swapn
            for (genvar k = 0; k < NBYTES; k++) begin : g_byte
                assign swapped[8*(NBYTES-1-k) +: 8] = if_inst[8*k +: 8];
            end
        end else begin : g_pass
            assign swapped = if_inst;
        end
    endgenerate

    // if_ready comes from the registered count only, keeping id_ready off the IF path.
    assign if_ready = !full;
    assign id_valid = !empty;
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready && !flush;

    if_id_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata ({if_pc, swapped}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign id_pc       = empty ? '0 : head[W-1 -: ADDR_W];
    assign id_inst     = empty ? '0 : head[INST_W-1:0];
    assign id_misalign = !empty && (head[INST_W +: 2] != 2'b00);

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (if_valid && !if_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (id_ready && !id_valid && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
